// File: rtl/write_buffer_if.sv
// -----------------------------------------------------------------------------
// write_buffer_if
// Bundles the store-request handshake (cache controller side) and the
// main-memory write handshake of the write buffer.
//   wr_valid / wr_addr / wr_data : store request into the buffer
//   wr_ready                     : buffer can take a store this cycle
//   mem_write / mem_address /
//   mem_write_data               : write request towards main memory
//   mem_ready                    : main memory completed the current write
// Modports:
//   slave  - the write buffer itself
//   master - the environment (cache controller + main memory)
// -----------------------------------------------------------------------------
interface write_buffer_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 10
);
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_ready;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [WIDTH-1:0]  mem_write_data;
   logic              mem_ready;

   modport slave (
      input  wr_valid, wr_addr, wr_data, mem_ready,
      output wr_ready, mem_write, mem_address, mem_write_data
   );

   modport master (
      output wr_valid, wr_addr, wr_data, mem_ready,
      input  wr_ready, mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/write_buffer.sv
// -----------------------------------------------------------------------------
// write_buffer
// In-order store buffer between a cache controller and main memory. Stores are
// queued in a DEPTH-entry FIFO and drained one at a time by a two-state
// (IDLE/BUSY) FSM. A block-granular address compare tells a pending cache
// refill whether it would overtake a buffered store to the same 4-word block.
// Ports:
//   clk           : clock, rising edge
//   rst           : asynchronous reset, active low
//   bus           : store request + main-memory write handshakes (slave view)
//   rd_check_addr : word address of a pending refill
//   rd_conflict   : a valid entry lies in the same 4-word block (combinational)
//   count         : number of valid entries (0..DEPTH)
//   empty         : count == 0
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module write_buffer #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   write_buffer_if.slave            bus,
   input  logic [ADDR_W-1:0]        rd_check_addr,
   output logic                     rd_conflict,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   addr_mem_r [DEPTH];
   logic [WIDTH-1:0]    data_mem_r [DEPTH];
   logic [PW-1:0]       head_r;
   logic [PW-1:0]       tail_r;
   logic [CW-1:0]       count_r;
   logic                mem_write_r;
   logic [ADDR_W-1:0]   mem_address_r;
   logic [WIDTH-1:0]    mem_write_data_r;

   logic                push_s;
   logic                pop_s;
   logic [CW-1:0]       count_next_s;
   logic [PW-1:0]       head_next_s;
   logic [ADDR_W-1:0]   next_addr_s;
   logic [WIDTH-1:0]    next_data_s;
   logic [DEPTH-1:0]    valid_s;
   logic                rd_conflict_s;

   // Push/pop decode, next count and the entry that becomes head after a pop.
   always_comb begin
      push_s       = bus.wr_valid && (count_r != CW'(DEPTH));
      pop_s        = (state_r == BUSY) && bus.mem_ready;
      head_next_s  = head_r + PW'(1);
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase
      // With one entry left, the store pushed on this very edge becomes the
      // new head but is not in the storage array yet, so forward it.
      if (push_s && (tail_r == head_next_s)) begin
         next_addr_s = bus.wr_addr;
         next_data_s = bus.wr_data;
      end else begin
         next_addr_s = addr_mem_r[head_next_s];
         next_data_s = data_mem_r[head_next_s];
      end
   end

   // Entry storage; never reset, validity comes from head/count alone.
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_mem_r[tail_r] <= bus.wr_addr;
         data_mem_r[tail_r] <= bus.wr_data;
      end
   end

   // Pointers, count and the drain FSM with its registered memory outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_r           <= '0;
         tail_r           <= '0;
         count_r          <= '0;
         state_r          <= IDLE;
         mem_write_r      <= 1'b0;
         mem_address_r    <= '0;
         mem_write_data_r <= '0;
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PW'(1);
         end
         if (pop_s) begin
            head_r <= head_next_s;
         end
         count_r <= count_next_s;
         case (state_r)
            IDLE: begin
               // mem_ready is deliberately not looked at here.
               if (count_r != CW'(0)) begin
                  state_r          <= BUSY;
                  mem_write_r      <= 1'b1;
                  mem_address_r    <= addr_mem_r[head_r];
                  mem_write_data_r <= data_mem_r[head_r];
               end
            end
            BUSY: begin
               if (pop_s) begin
                  if (count_next_s != CW'(0)) begin
                     mem_address_r    <= next_addr_s;
                     mem_write_data_r <= next_data_s;
                  end else begin
                     state_r          <= IDLE;
                     mem_write_r      <= 1'b0;
                     mem_address_r    <= '0;
                     mem_write_data_r <= '0;
                  end
               end
            end
            default: begin
               state_r          <= IDLE;
               mem_write_r      <= 1'b0;
               mem_address_r    <= '0;
               mem_write_data_r <= '0;
            end
         endcase
      end
   end

   // Block-granular conflict check over the entries currently held.
   always_comb begin
      rd_conflict_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         // Entry i is valid when its distance from head is below count.
         valid_s[i] = ({1'b0, PW'(i) - head_r} < count_r);
         if (valid_s[i] && (addr_mem_r[i][ADDR_W-1:2] == rd_check_addr[ADDR_W-1:2])) begin
            rd_conflict_s = 1'b1;
         end else begin
            rd_conflict_s = rd_conflict_s;
         end
      end
   end

   assign rd_conflict        = rd_conflict_s;
   assign count              = count_r;
   assign empty              = (count_r == CW'(0));
   assign bus.wr_ready       = (count_r != CW'(DEPTH));
   assign bus.mem_write      = mem_write_r;
   assign bus.mem_address    = mem_address_r;
   assign bus.mem_write_data = mem_write_data_r;
endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;
   logic       clk;
   logic       rst;
   logic [9:0] rd_check_addr;
   logic       rd_conflict;
   logic [2:0] count;
   logic       empty;

   int checks = 0;
   int errors = 0;

   write_buffer_if bus_if ();

   write_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus_if),
      .rd_check_addr (rd_check_addr),
      .rd_conflict   (rd_conflict),
      .count         (count),
      .empty         (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [9:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t q[$];
   bit   busy;

   function automatic logic model_conflict(input logic [9:0] ca);
      foreach (q[i]) begin
         if (q[i].a[9:2] == ca[9:2]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Apply inputs, advance the model by one edge, clock the DUT, compare.
   task automatic drive_step(input logic wv, input logic [9:0] wa, input logic [31:0] wd,
                             input logic mr, input logic [9:0] ca);
      int   sz0;
      bit   acc;
      bit   pop;
      ent_t e;
      bus_if.wr_valid  = wv;
      bus_if.wr_addr   = wa;
      bus_if.wr_data   = wd;
      bus_if.mem_ready = mr;
      rd_check_addr    = ca;
      sz0 = q.size();
      acc = wv && (sz0 != 4);
      pop = busy && mr;
      if (pop) q.delete(0);
      if (acc) begin
         e.a = wa;
         e.d = wd;
         q.push_back(e);
      end
      if (!busy) busy = (sz0 != 0);
      else if (pop) busy = (q.size() != 0);
      @(posedge clk);
      #1;
      chk("m_mem_write", bus_if.mem_write, busy);
      chk("m_mem_address", bus_if.mem_address, busy ? q[0].a : 10'h000);
      chk("m_mem_data", bus_if.mem_write_data, busy ? q[0].d : 32'h0);
      chk("m_count", count, q.size());
      chk("m_wr_ready", bus_if.wr_ready, q.size() != 4);
      chk("m_empty", empty, q.size() == 0);
      chk("m_conflict", rd_conflict, model_conflict(ca));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus_if.wr_valid  = 1'b0;
      bus_if.wr_addr   = 10'h000;
      bus_if.wr_data   = 32'h0;
      bus_if.mem_ready = 1'b0;
      rd_check_addr    = 10'h000;
      q.delete();
      busy = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        wv;
      logic [9:0]  wa;
      logic [31:0] wd;
      logic        mr;
      logic [9:0]  ca;
      logic        e_mw;
      logic [9:0]  e_ad;
      logic [31:0] e_dt;
      logic [2:0]  e_cnt;
      logic        e_cf;
   } vec_t;

   vec_t tbl[16];

   initial begin
      // single store, held 3 cycles, then acknowledged
      tbl[0]  = '{1'b1, 10'h055, 32'hDEADBEEF, 1'b0, 10'h000, 1'b0, 10'h000, 32'h0,        3'd1, 1'b0};
      tbl[1]  = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h054, 1'b1, 10'h055, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[2]  = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h058, 1'b1, 10'h055, 32'hDEADBEEF, 3'd1, 1'b0};
      tbl[3]  = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h057, 1'b1, 10'h055, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[4]  = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h056, 1'b1, 10'h055, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[5]  = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h055, 1'b0, 10'h000, 32'h0,        3'd0, 1'b0};
      // mem_ready in IDLE with empty buffer
      tbl[6]  = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h055, 1'b0, 10'h000, 32'h0,        3'd0, 1'b0};
      // fill to 4 (pointer wrap), 5th dropped, push while full+pop dropped
      tbl[7]  = '{1'b1, 10'h104, 32'h11111111, 1'b0, 10'h107, 1'b0, 10'h000, 32'h0,        3'd1, 1'b1};
      tbl[8]  = '{1'b1, 10'h200, 32'h22222222, 1'b0, 10'h108, 1'b1, 10'h104, 32'h11111111, 3'd2, 1'b0};
      tbl[9]  = '{1'b1, 10'h300, 32'h33333333, 1'b0, 10'h107, 1'b1, 10'h104, 32'h11111111, 3'd3, 1'b1};
      tbl[10] = '{1'b1, 10'h3FF, 32'h44444444, 1'b0, 10'h3FC, 1'b1, 10'h104, 32'h11111111, 3'd4, 1'b1};
      tbl[11] = '{1'b1, 10'h001, 32'h55555555, 1'b0, 10'h104, 1'b1, 10'h104, 32'h11111111, 3'd4, 1'b1};
      tbl[12] = '{1'b1, 10'h002, 32'h66666666, 1'b1, 10'h107, 1'b1, 10'h200, 32'h22222222, 3'd3, 1'b0};
      tbl[13] = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h301, 1'b1, 10'h300, 32'h33333333, 3'd2, 1'b1};
      tbl[14] = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h3FE, 1'b1, 10'h3FF, 32'h44444444, 3'd1, 1'b1};
      tbl[15] = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h3FF, 1'b0, 10'h000, 32'h0,        3'd0, 1'b0};

      // ---- reset state, checked before any clock edge ----
      rst = 1'b0;
      bus_if.wr_valid  = 1'b0;
      bus_if.wr_addr   = 10'h000;
      bus_if.wr_data   = 32'h0;
      bus_if.mem_ready = 1'b0;
      rd_check_addr    = 10'h000;
      #3;
      chk("rst_mem_write", bus_if.mem_write, 1'b0);
      chk("rst_mem_address", bus_if.mem_address, 10'h000);
      chk("rst_mem_data", bus_if.mem_write_data, 32'h0);
      chk("rst_count", count, 3'd0);
      chk("rst_wr_ready", bus_if.wr_ready, 1'b1);
      chk("rst_empty", empty, 1'b1);
      chk("rst_conflict", rd_conflict, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // ---- table ----
      for (int i = 0; i < 16; i++) begin
         bus_if.wr_valid  = tbl[i].wv;
         bus_if.wr_addr   = tbl[i].wa;
         bus_if.wr_data   = tbl[i].wd;
         bus_if.mem_ready = tbl[i].mr;
         rd_check_addr    = tbl[i].ca;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_mem_write", i), bus_if.mem_write, tbl[i].e_mw);
         chk($sformatf("v%0d_mem_address", i), bus_if.mem_address, tbl[i].e_ad);
         chk($sformatf("v%0d_mem_data", i), bus_if.mem_write_data, tbl[i].e_dt);
         chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
         chk($sformatf("v%0d_wr_ready", i), bus_if.wr_ready, tbl[i].e_cnt != 3'd4);
         chk($sformatf("v%0d_empty", i), empty, tbl[i].e_cnt == 3'd0);
         chk($sformatf("v%0d_conflict", i), rd_conflict, tbl[i].e_cf);
      end

      // ---- a store being pushed this cycle does not raise a conflict ----
      do_reset();
      bus_if.wr_valid = 1'b1;
      bus_if.wr_addr  = 10'h123;
      bus_if.wr_data  = 32'hCAFE0001;
      rd_check_addr   = 10'h121;
      #1;
      chk("push_same_cycle_conflict", rd_conflict, 1'b0);
      drive_step(1'b1, 10'h123, 32'hCAFE0001, 1'b0, 10'h121);

      // ---- simultaneous push and pop at count 2, across many wraps ----
      drive_step(1'b1, 10'h2A0, 32'hCAFE0002, 1'b0, 10'h2A0);
      for (int n = 0; n < 12; n++) begin
         drive_step(1'b1, 10'($urandom_range(0, 1023)), $urandom, 1'b1, 10'h2A3);
         chk("pushpop_count2", count, 3'd2);
      end

      // ---- reset in the middle of a drain ----
      do_reset();
      drive_step(1'b1, 10'h010, 32'hA0000001, 1'b0, 10'h010);
      drive_step(1'b1, 10'h020, 32'hA0000002, 1'b0, 10'h010);
      drive_step(1'b1, 10'h030, 32'hA0000003, 1'b0, 10'h010);
      bus_if.wr_valid = 1'b0;
      rst = 1'b0;
      #2;
      chk("mid_rst_mem_write", bus_if.mem_write, 1'b0);
      chk("mid_rst_mem_address", bus_if.mem_address, 10'h000);
      chk("mid_rst_mem_data", bus_if.mem_write_data, 32'h0);
      chk("mid_rst_count", count, 3'd0);
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_wr_ready", bus_if.wr_ready, 1'b1);
      chk("mid_rst_conflict", rd_conflict, 1'b0);
      q.delete();
      busy = 1'b0;
      #2;
      rst = 1'b1;
      for (int n = 0; n < 4; n++) begin
         drive_step(1'b0, 10'h010, 32'h0, n[0], 10'h010);
      end

      // ---- randomized traffic against the reference model ----
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [9:0] ca;
         if ((q.size() != 0) && ($urandom_range(0, 1) == 1))
            ca = q[$urandom_range(0, q.size() - 1)].a ^ 10'($urandom_range(0, 7));
         else
            ca = 10'($urandom_range(0, 1023));
         drive_step($urandom_range(0, 99) < 55, 10'($urandom_range(0, 1023)), $urandom,
                    $urandom_range(0, 99) < 45, ca);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 10, word-address width.
REQ-003 Parameter DEPTH, default 4, number of buffer entries; power of two.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-006 wr_valid  input  1  store request from the cache controller.
REQ-007 wr_addr  input  ADDR_W  word address of the store.
REQ-008 wr_data  input  WIDTH  store data.
REQ-009 wr_ready  output  1  buffer can accept a store this cycle.
REQ-010 rd_check_addr  input  ADDR_W  word address of a pending cache refill.
REQ-011 rd_conflict  output  1  a buffered store targets the same block as rd_check_addr.
REQ-012 mem_write  output  1  write request to main memory.
REQ-013 mem_address  output  ADDR_W  main-memory word address.
REQ-014 mem_write_data  output  WIDTH  main-memory write data.
REQ-015 mem_ready  input  1  main memory has completed the current write.
REQ-016 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-017 empty  output  1  count == 0.

Function
REQ-018 Storage SHALL be an in-order FIFO of DEPTH {addr, data} entries, with wrapping head/tail pointers and a count of 0..DEPTH; no coalescing or reordering.
REQ-019 wr_ready SHALL equal (count != DEPTH), decoded from registered count only; a push SHALL NOT be accepted when full, even if a pop happens in the same cycle.
REQ-020 Push: when wr_valid && wr_ready at a rising edge, {wr_addr, wr_data} SHALL be written at tail, and tail SHALL advance modulo DEPTH.
REQ-021 The drain FSM SHALL have two states, IDLE and BUSY; mem_write SHALL be 1 exactly in BUSY.
REQ-022 IDLE -> BUSY at the edge where registered count != 0; this gives a one-cycle latency from a push into an empty buffer to mem_write high.
REQ-023 In BUSY, mem_address and mem_write_data SHALL present the head entry and SHALL stay stable until mem_ready is sampled high.
REQ-024 In BUSY with mem_ready = 1: head SHALL advance (pop). The next state SHALL be BUSY if the post-update count != 0 (back-to-back drain), else IDLE.
REQ-025 mem_ready SHALL be ignored in IDLE.
REQ-026 A simultaneous push and pop SHALL leave count unchanged; push only: count +1; pop only: count -1.
REQ-027 In IDLE, mem_address and mem_write_data SHALL be 0.
REQ-028 rd_conflict SHALL be combinational: 1 when any valid entry satisfies addr[ADDR_W-1:2] == rd_check_addr[ADDR_W-1:2] (same 4-word block), else 0.
REQ-029 rd_conflict SHALL include the head entry while it is being written; it SHALL NOT include a store being pushed in the same cycle.
REQ-030 empty SHALL equal (count == 0).

Reset
REQ-031 With rst = 0, all of the following SHALL hold immediately, without waiting for clk: head = tail = count = 0, state = IDLE, mem_write = 0, mem_address = 0, mem_write_data = 0, wr_ready = 1, empty = 1, rd_conflict = 0.
REQ-032 Reset mid-drain SHALL discard all entries, including an unacknowledged head.
REQ-033 After release, the first mem_write SHALL follow only a new push.
REQ-034 Entry storage need not be cleared on reset; valid tracking alone SHALL guarantee correctness.

Verification
REQ-035 Single store: push addr 0x055, data 0xDEADBEEF into an empty buffer at edge N -> mem_write = 1 after edge N+1 with addr 0x055 and data 0xDEADBEEF; hold mem_ready = 0 for 3 cycles -> outputs stable; mem_ready = 1 -> count = 0 and IDLE next cycle.
REQ-036 Fill: push 4 stores with mem_ready = 0 -> count = 4 and wr_ready = 0; a 5th wr_valid is dropped; drain with mem_ready = 1 -> writes leave in push order, back-to-back with no IDLE gap.
REQ-037 Simultaneous push and pop at count = 2 -> count stays 2 and FIFO order is preserved across pointer wrap (run more than 8 total stores).
REQ-038 Conflict: buffer holds addr 0x104, rd_check_addr = 0x107 -> rd_conflict = 1; rd_check_addr = 0x108 -> rd_conflict = 0; after the 0x104 entry drains -> rd_conflict = 0.
REQ-039 Reset mid-drain: count = 3 in BUSY, assert rst between edges -> mem_write = 0 and count = 0 before the next edge; after release with no push -> mem_write stays 0.
REQ-040 mem_ready pulsed high in IDLE with an empty buffer -> no change to count or pointers.
